delay_chain_ctrl: RTL and testbench
===================================

DELAY_CHAIN_CTRL -- requirements
Module: delay_chain_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: payload width in bits.
REQ-002 SHALL have parameter LEN, default 4: stage count of the controlled delay chain; legal range LEN >= 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each: requester 0/1 offers a payload.
REQ-006 SHALL have ports req0_data/req1_data, input, DW each: requester payloads.
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1 each: payload accepted this cycle when valid&&ready.
REQ-008 SHALL have port chain_en, output, 1: shift enable driven to the delay chain.
REQ-009 SHALL have port chain_in, output, DW: data driven into chain stage 0.
REQ-010 SHALL have port chain_out, input, DW: data from the chain's last stage.
REQ-011 SHALL have ports rsp0_valid/rsp1_valid, output, 1 each; rsp0_ready/rsp1_ready, input, 1 each; rsp0_data/rsp1_data, output, DW each: per-requester return streams.
REQ-012 SHALL have port drain_req, input, 1: request to stop accepting and empty the chain.
REQ-013 SHALL have port drain_done, output, 1: chain empty after drain.
REQ-014 SHALL have port occupancy, output, $clog2(LEN+1): count of valid entries in flight.

Function
REQ-015 SHALL keep a LEN-entry shadow register of {valid, tag} per stage, shifted only when chain_en=1, so shadow stage i always describes chain stage i.
REQ-016 SHALL drive chain_en = !tail_valid || rsp_ready[tail_tag] (advance); the chain SHALL never shift while an unconsumed valid tail exists.
REQ-017 SHALL, in state RUN, grant one requester per cycle by round-robin: if both valid, grant the one not granted last; if one valid, grant it.
REQ-018 SHALL assert reqX_ready only when X is granted, state is RUN, advance=1 and rst=0; all other reqX_ready = 0.
REQ-019 SHALL update the last-grant pointer only on an accepted transfer.
REQ-020 SHALL, on accept, drive chain_in = granted data and insert {1, tag}; on advance without accept, drive chain_in = 0 and insert {0, x} (bubble).
REQ-021 SHALL drive rspX_valid = tail_valid && tail_tag==X, rspX_data = chain_out for both X (data ignored when not valid).
REQ-022 SHALL give latency LEN cycles with no back-pressure: accept in cycle t -> rsp valid in cycle t+LEN.
REQ-023 SHALL hold rspX_valid and rspX_data stable while rspX_ready=0 (chain frozen by REQ-016).
REQ-024 SHALL update occupancy +1 on accept, -1 on tail consumed, unchanged when both or neither occur in one cycle; never exceeds LEN.
REQ-025 SHALL implement FSM states RUN, DRAIN, DONE: RUN->DRAIN when drain_req=1; DRAIN->DONE when occupancy=0; DONE->RUN when drain_req=0.
REQ-026 SHALL accept nothing in DRAIN and DONE; chain continues to advance with bubbles so in-flight entries complete normally.
REQ-027 SHALL assert drain_done=1 exactly while in DONE.
REQ-028 SHALL, if drain_req rises when occupancy already 0, pass through DRAIN for one cycle before DONE.

Reset
REQ-029 SHALL, with rst=1 on a clock edge, clear all shadow valid bits, set occupancy=0, state=RUN, last-grant pointer=1 (requester 0 wins first tie).
REQ-030 SHALL force req0_ready=req1_ready=0 while rst=1; rsp*_valid=0 and drain_done=0 from the first cycle after reset.
REQ-031 SHALL discard in-flight entries on reset mid-operation; stale chain data is masked by cleared valid bits, no chain reset required.

Verification
REQ-032 SHALL cover: LEN=4, req0 sends 0xA5 at cycle 10, rsp0_ready=1 -> rsp0_valid=1, rsp0_data=0xA5 at cycle 14, rsp1_valid=0.
REQ-033 SHALL cover: both requesters valid continuously with payloads 0x01..0x08 -> grants alternate 0,1,0,1 starting with 0; responses return in order tagged correctly.
REQ-034 SHALL cover: fill with 4 entries, rsp0_ready=0 for 5 cycles -> chain_en=0, req*_ready=0, occupancy=4, tail data stable; release -> drains in order.
REQ-035 SHALL cover: drain_req=1 with occupancy=3 -> no accepts, drain_done rises the cycle after occupancy reaches 0; drop drain_req -> RUN, accepts resume next cycle.
REQ-036 SHALL cover: rst=1 for one cycle with occupancy=2 -> occupancy=0, no rsp*_valid ever for those entries, next tie grants requester 0.
REQ-037 SHALL cover: LEN=1, accept and tail consume in the same cycle -> occupancy stays 1, throughput one per cycle.

Source files
------------

// File: rtl/delay_chain_ctrl.sv
// Controller for an external LEN-stage delay chain shared by two requesters.
// Tracks per-stage {valid, tag} and routes the chain tail back to its owner.
module delay_chain_ctrl #(
    parameter int DW  = 8,
    parameter int LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [DW-1:0]            req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [DW-1:0]            req1_data,
    output logic                     req1_ready,
    output logic                     chain_en,
    output logic [DW-1:0]            chain_in,
    input  logic [DW-1:0]            chain_out,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [DW-1:0]            rsp0_data,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DW-1:0]            rsp1_data,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic [$clog2(LEN+1)-1:0] occupancy
);

    localparam int OW = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [LEN-1:0] sh_valid;
    logic [LEN-1:0] sh_tag;
    logic           last;
    logic [OW-1:0]  occ;

    logic           tail_valid;
    logic           tail_tag;
    logic           advance;
    logic           gnt0;
    logic           gnt1;
    logic           run_ok;
    logic           accept;
    logic           consume;

    assign tail_valid = sh_valid[LEN-1];
    assign tail_tag   = sh_tag[LEN-1];

    // The chain may only move when the tail is empty or being taken.
    assign advance  = !tail_valid || (tail_tag ? rsp1_ready : rsp0_ready);
    assign chain_en = advance;

    // Round-robin: on a tie, the requester not granted last wins.
    assign gnt0 = req0_valid && (!req1_valid || last);
    assign gnt1 = req1_valid && (!req0_valid || !last);

    assign run_ok     = (state == RUN) && advance && !rst;
    assign req0_ready = gnt0 && run_ok;
    assign req1_ready = gnt1 && run_ok;
    assign accept     = req0_ready || req1_ready;
    assign consume    = tail_valid && advance;

    assign rsp0_valid = tail_valid && !tail_tag;
    assign rsp1_valid = tail_valid && tail_tag;
    assign rsp0_data  = chain_out;
    assign rsp1_data  = chain_out;

    assign drain_done = (state == DONE);
    assign occupancy  = occ;

    // Accepted payload enters stage 0; otherwise a zero bubble.
    always_comb begin
        chain_in = '0;
        if (req1_ready) begin
            chain_in = req1_data;
        end else if (req0_ready) begin
            chain_in = req0_data;
        end
    end

    // Shadow {valid, tag} shifts in lockstep with the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_valid <= '0;
            sh_tag   <= '0;
        end else if (advance) begin
            for (int i = LEN - 1; i > 0; i--) begin
                sh_valid[i] <= sh_valid[i-1];
                sh_tag[i]   <= sh_tag[i-1];
            end
            sh_valid[0] <= accept;
            sh_tag[0]   <= req1_ready;
        end
    end

    // Last-grant pointer moves only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= req1_ready;
        end
    end

    // In-flight count: +1 on accept, -1 on tail consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else if (accept && !consume) begin
            occ <= occ + OW'(1);
        end else if (!accept && consume) begin
            occ <= occ - OW'(1);
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (drain_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (occ == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!drain_req) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_delay_chain_ctrl.sv
// Directed bench for delay_chain_ctrl: LEN=4 instance plus a LEN=1 instance.
// Each instance drives a small behavioural delay chain from chain_en/chain_in.
module tb_delay_chain_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       chain_en;
    logic [7:0] chain_in, chain_out;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_data, rsp1_data;
    logic       drain_req, drain_done;
    logic [2:0] occupancy;

    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [7:0] b_req0_data, b_req1_data;
    logic       b_chain_en;
    logic [7:0] b_chain_in, b_chain_out;
    logic       b_rsp0_valid, b_rsp1_valid, b_rsp0_ready, b_rsp1_ready;
    logic [7:0] b_rsp0_data, b_rsp1_data;
    logic       b_drain_req, b_drain_done;
    logic [0:0] b_occupancy;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] ch [0:3];
    logic [7:0] ch1;

    always #5 clk = ~clk;

    // External chain models; never reset, so stale data must be masked.
    always @(posedge clk) begin
        if (chain_en) begin
            ch[0] <= chain_in;
            ch[1] <= ch[0];
            ch[2] <= ch[1];
            ch[3] <= ch[2];
        end
    end
    assign chain_out = ch[3];

    always @(posedge clk) begin
        if (b_chain_en) ch1 <= b_chain_in;
    end
    assign b_chain_out = ch1;

    delay_chain_ctrl #(.DW(8), .LEN(4)) u0 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .chain_en(chain_en), .chain_in(chain_in), .chain_out(chain_out),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .drain_req(drain_req), .drain_done(drain_done), .occupancy(occupancy)
    );

    delay_chain_ctrl #(.DW(8), .LEN(1)) u1 (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
        .chain_en(b_chain_en), .chain_in(b_chain_in), .chain_out(b_chain_out),
        .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_data(b_rsp0_data),
        .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_data(b_rsp1_data),
        .drain_req(b_drain_req), .drain_done(b_drain_done), .occupancy(b_occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int i0;
        int i1;
        int occ_exp;
        logic g0;
        logic [7:0] d;

        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drain_req = 1'b0;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0;
        b_req0_data = 8'h00; b_req1_data = 8'h00;
        b_rsp0_ready = 1'b1; b_rsp1_ready = 1'b1;
        b_drain_req = 1'b0;

        #2;
        chk("rst_rdy0", 32'(req0_ready), 32'd0);
        step();
        step();

        // reset state
        rst = 1'b0;
        req0_valid = 1'b0;
        #2;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_rv0", 32'(rsp0_valid), 32'd0);
        chk("rst_rv1", 32'(rsp1_valid), 32'd0);
        chk("rst_done", 32'(drain_done), 32'd0);
        step();

        // single transfer, latency LEN
        req0_valid = 1'b1; req0_data = 8'hA5;
        #2;
        chk("a_rdy", 32'(req0_ready), 32'd1);
        chk("a_cin", 32'(chain_in), 32'hA5);
        step();
        req0_valid = 1'b0;
        #2;
        chk("a_bub", 32'(chain_in), 32'd0);
        chk("a_occ", 32'(occupancy), 32'd1);
        step();
        step();
        #2;
        chk("a_early", 32'(rsp0_valid), 32'd0);
        step();
        #2;
        chk("a_rv0", 32'(rsp0_valid), 32'd1);
        chk("a_rd0", 32'(rsp0_data), 32'hA5);
        chk("a_rv1", 32'(rsp1_valid), 32'd0);
        step();
        #2;
        chk("a_gone", 32'(rsp0_valid), 32'd0);
        chk("a_occ0", 32'(occupancy), 32'd0);
        step();

        // alternating grants from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        i0 = 0;
        i1 = 0;
        for (int k = 0; k <= 12; k++) begin
            if (k < 8) begin
                req0_valid = 1'b1; req1_valid = 1'b1;
                req0_data = 8'(8'h01 + 2 * i0);
                req1_data = 8'(8'h02 + 2 * i1);
            end else begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #2;
            if (k < 8) begin
                g0 = (k % 2 == 0);
                chk("b_g0", 32'(req0_ready), 32'(g0));
                chk("b_g1", 32'(req1_ready), 32'(!g0));
                chk("b_cin", 32'(chain_in), 32'(k + 1));
                if (g0) i0++; else i1++;
            end
            if (k >= 4 && k < 12) begin
                d = 8'(k - 3);
                chk("b_rv0", 32'(rsp0_valid), 32'((k - 4) % 2 == 0));
                chk("b_rv1", 32'(rsp1_valid), 32'((k - 4) % 2 == 1));
                chk("b_rd", 32'(((k - 4) % 2 == 0) ? rsp0_data : rsp1_data), 32'(d));
            end
            occ_exp = (k < 4) ? k : ((k <= 8) ? 4 : 12 - k);
            chk("b_occ", 32'(occupancy), 32'(occ_exp));
            step();
        end

        // back-pressure: fill, stall five cycles, release
        rsp0_ready = 1'b0;
        req0_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req0_data = 8'(8'h10 + k);
            #2;
            chk("c_fill", 32'(req0_ready), 32'd1);
            step();
        end
        req0_data = 8'h14;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("c_en", 32'(chain_en), 32'd0);
            chk("c_rdy", 32'(req0_ready), 32'd0);
            chk("c_occ", 32'(occupancy), 32'd4);
            chk("c_rv", 32'(rsp0_valid), 32'd1);
            chk("c_rd", 32'(rsp0_data), 32'h10);
            step();
        end
        rsp0_ready = 1'b1;
        req0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("c_dv", 32'(rsp0_valid), 32'd1);
            chk("c_dd", 32'(rsp0_data), 32'(8'h10 + k));
            chk("c_docc", 32'(occupancy), 32'(4 - k));
            step();
        end
        #2;
        chk("c_empty", 32'(occupancy), 32'd0);
        step();

        // drain with three in flight
        req0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req0_data = 8'(8'h20 + k);
            #2;
            chk("d_fill", 32'(req0_ready), 32'd1);
            step();
        end
        req0_valid = 1'b0;
        drain_req = 1'b1;
        #2;
        chk("d_occ3", 32'(occupancy), 32'd3);
        step();
        req0_valid = 1'b1; req0_data = 8'h30;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("d_noacc", 32'(req0_ready), 32'd0);
            chk("d_ndone", 32'(drain_done), 32'd0);
            chk("d_occ", 32'(occupancy), 32'(3 - k));
            if (k < 3) chk("d_rd", 32'(rsp0_data), 32'(8'h20 + k));
            step();
        end
        #2;
        chk("d_done", 32'(drain_done), 32'd1);
        chk("d_rdy_done", 32'(req0_ready), 32'd0);
        step();
        drain_req = 1'b0;
        #2;
        chk("d_done2", 32'(drain_done), 32'd1);
        chk("d_rdy_done2", 32'(req0_ready), 32'd0);
        step();
        #2;
        chk("d_run", 32'(drain_done), 32'd0);
        chk("d_resume", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        step();
        step();
        #2;
        chk("d_rv", 32'(rsp0_valid), 32'd1);
        chk("d_rd30", 32'(rsp0_data), 32'h30);
        step();
        #2;
        chk("d_occ0", 32'(occupancy), 32'd0);
        step();

        // drain request while already empty
        drain_req = 1'b1;
        #2;
        chk("e0_done", 32'(drain_done), 32'd0);
        step();
        #2;
        chk("e1_drain", 32'(drain_done), 32'd0);
        step();
        drain_req = 1'b0;
        #2;
        chk("e2_done", 32'(drain_done), 32'd1);
        step();
        #2;
        chk("e3_run", 32'(drain_done), 32'd0);
        step();

        // reset mid-flight discards entries, tie goes to requester 0
        req1_valid = 1'b1; req1_data = 8'h41;
        #2;
        chk("r_g1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h40;
        #2;
        chk("r_g0", 32'(req0_ready), 32'd1);
        step();
        rst = 1'b1;
        #2;
        chk("r_rdy_rst", 32'(req0_ready), 32'd0);
        chk("r_occ2", 32'(occupancy), 32'd2);
        step();
        rst = 1'b0;
        req0_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #2;
            chk("r_rv0", 32'(rsp0_valid), 32'd0);
            chk("r_rv1", 32'(rsp1_valid), 32'd0);
            if (k == 0) chk("r_occ0", 32'(occupancy), 32'd0);
            step();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #2;
        chk("r_tie0", 32'(req0_ready), 32'd1);
        chk("r_tie1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();

        // LEN=1: accept and consume in one cycle
        b_req0_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b_req0_data = 8'(8'h50 + k);
            #2;
            chk("f_rdy", 32'(b_req0_ready), 32'd1);
            if (k > 0) begin
                chk("f_occ", 32'(b_occupancy), 32'd1);
                chk("f_rv", 32'(b_rsp0_valid), 32'd1);
                chk("f_rd", 32'(b_rsp0_data), 32'(8'h50 + k - 1));
            end else begin
                chk("f_occ0", 32'(b_occupancy), 32'd0);
            end
            step();
        end
        b_req0_valid = 1'b0;
        #2;
        chk("f_last", 32'(b_rsp0_data), 32'h55);
        chk("f_lastv", 32'(b_rsp0_valid), 32'd1);
        step();
        #2;
        chk("f_end_occ", 32'(b_occupancy), 32'd0);
        chk("f_end_rv", 32'(b_rsp0_valid), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
